// File: rtl/cl_capture_sched.sv
// cl_capture_sched: decodes PC commands, arms/aborts capture, runs a stall watchdog
// and arbitrates the fpga_msg port between payload words and reply words.
module cl_capture_sched #(
  parameter int N_FRAME_SIZE = 20,
  parameter int WDOG_W       = 24,
  parameter int DROP_W       = 16
) (
  input  logic                    bus_clk,
  input  logic                    reset_n,
  input  logic                    pc_msg_pending,
  output logic                    pc_msg_ack,
  input  logic [31:0]             pc_msg,
  output logic                    cap_arm,
  output logic [N_FRAME_SIZE-1:0] cap_frames,
  output logic                    cap_abort,
  input  logic                    cap_done,
  input  logic [31:0]             cap_msg,
  input  logic                    cap_msg_valid,
  input  logic                    fpga_msg_full,
  output logic [31:0]             fpga_msg,
  output logic                    fpga_msg_valid,
  output logic                    busy,
  output logic [DROP_W-1:0]       drop_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ABORTING = 2'd2} state_t;
  state_t r_state, w_next;
  logic r_ack, r_arm, r_abort, r_rep_full, r_done_p, r_valid;
  logic [31:0] r_rep, r_msg;
  logic [N_FRAME_SIZE-1:0] r_frames;
  logic [WDOG_W-1:0] r_wdog;
  logic [DROP_W-1:0] r_drop;
  logic w_drain, w_slot_free, w_done, w_wdog, w_acc, w_wr, w_arm, w_abort, w_clr_drop;
  logic [11:0] w_op;
  logic [19:0] w_arg, w_pay;
  logic [3:0] w_code;
  logic [31:0] w_dx;
  logic [17:0] w_d18;
  assign w_op        = pc_msg[31:20];
  assign w_arg       = pc_msg[19:0];
  assign w_drain     = r_rep_full && !cap_msg_valid && !fpga_msg_full;
  assign w_slot_free = !r_rep_full || w_drain;
  // a done pulse that cannot be reported yet is remembered so its reply is never lost
  assign w_done      = (cap_done || r_done_p) && r_state != IDLE;
  assign w_wdog      = r_state == RUN && !cap_msg_valid && &r_wdog;
  assign w_acc       = pc_msg_pending && !r_ack && !r_rep_full && !w_done && !w_wdog;
  assign w_dx        = 32'(r_drop);
  assign w_d18       = |w_dx[31:18] ? 18'h3FFFF : w_dx[17:0];
  always_comb begin
    w_next     = r_state;
    w_wr       = 1'b0;
    w_code     = 4'd0;
    w_pay      = 20'd0;
    w_arm      = 1'b0;
    w_abort    = 1'b0;
    w_clr_drop = 1'b0;
    if (w_done) begin
      if (w_slot_free) begin
        w_next = IDLE;
        w_wr   = 1'b1;
        w_code = r_state == RUN ? 4'd4 : 4'd5;
        w_pay  = r_state == RUN ? 20'(r_frames) : 20'd0;
      end
    end else if (w_wdog) begin
      if (w_slot_free) begin
        w_next  = ABORTING;
        w_abort = 1'b1;
        w_wr    = 1'b1;
        w_code  = 4'd6;
      end
    end else if (w_acc) begin
      w_wr   = 1'b1;
      w_code = 4'd2;
      w_pay  = w_arg;
      if (w_op == 12'h001 && r_state == IDLE && w_arg != '0) begin
        w_next     = RUN;
        w_arm      = 1'b1;
        w_code     = 4'd1;
        w_clr_drop = 1'b1;
      end else if (w_op == 12'h002 && r_state == RUN) begin
        w_next  = ABORTING;
        w_abort = 1'b1;
        w_code  = 4'd1;
      end else if (w_op == 12'h003) begin
        w_code = 4'd3;
        w_pay  = {r_state, w_d18};
      end else if (w_op != 12'h001 && w_op != 12'h002) begin
        w_pay = {8'd0, w_op};
      end
    end
  end
  always_ff @(posedge bus_clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack      <= 1'b0;
      r_arm      <= 1'b0;
      r_abort    <= 1'b0;
      r_frames   <= '0;
      r_done_p   <= 1'b0;
      r_wdog     <= '0;
      r_drop     <= '0;
      r_valid    <= 1'b0;
      r_msg      <= '0;
      r_rep_full <= 1'b0;
      r_rep      <= '0;
    end else begin
      r_ack    <= w_acc;
      r_arm    <= w_arm;
      r_abort  <= w_abort;
      r_frames <= w_arm ? N_FRAME_SIZE'(w_arg) : r_frames;
      r_done_p <= w_done && !w_slot_free;
      r_wdog   <= (r_state != RUN || cap_msg_valid) ? '0 : (&r_wdog ? r_wdog : r_wdog + WDOG_W'(1));
      r_drop   <= w_clr_drop ? '0 : (cap_msg_valid && fpga_msg_full && !(&r_drop)) ? r_drop + DROP_W'(1) : r_drop;
      r_valid  <= (cap_msg_valid && !fpga_msg_full) || w_drain;
      r_msg    <= (cap_msg_valid && !fpga_msg_full) ? cap_msg : (w_drain ? r_rep : r_msg);
      r_rep_full <= w_wr || (r_rep_full && !w_drain);
      r_rep    <= w_wr ? {8'hA5, w_code, w_pay} : r_rep;
    end
  end
  assign pc_msg_ack     = r_ack;
  assign cap_arm        = r_arm;
  assign cap_frames     = r_frames;
  assign cap_abort      = r_abort;
  assign fpga_msg       = r_msg;
  assign fpga_msg_valid = r_valid;
  assign busy           = r_state != IDLE;
  assign drop_cnt       = r_drop;
endmodule
